dma_bus_arbiter: RTL and testbench

- Two-master arbiter for the shared memory bus between the DMAC master port (M1) and the host/CPU master (M0).
- Converts each master's req/grant handshake into exclusive ownership of a single slave memory port.
- Muxes address, write strobe and write data from the granted master onto the bus, and broadcasts read data back to both masters.
- Round-robin on contention; a hold limit keeps the DMAC from starving the host during long descriptor chains.

---
 rtl/dma_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// Two-master round-robin arbiter for the shared DMA memory bus (M0 host, M1 DMAC).
// Grants are registered; the bus mux follows the registered state combinationally.
module dma_bus_arbiter #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              Clk,
   input  logic              reset_n,
   input  logic              M0_req,
   input  logic              M0_wr,
   input  logic [ADDR_W-1:0] M0_address,
   input  logic [DATA_W-1:0] M0_dout,
   output logic              M0_grant,
   input  logic              M1_req,
   input  logic              M1_wr,
   input  logic [ADDR_W-1:0] M1_address,
   input  logic [DATA_W-1:0] M1_dout,
   output logic              M1_grant,
   output logic              bus_sel,
   output logic              bus_wr,
   output logic [ADDR_W-1:0] bus_address,
   output logic [DATA_W-1:0] bus_dout,
   input  logic [DATA_W-1:0] bus_din,
   output logic [DATA_W-1:0] M_din
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   localparam logic [7:0] LP_MAX_HOLD   = 8'(MAX_HOLD);
   localparam logic       LP_PREEMPT_EN = (MAX_HOLD != 32'd0);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_hold_cnt;
   logic [7:0] w_hold_cnt_nxt;
   logic       r_last_grant;      // 1'b1 = M1 was granted last
   logic       w_last_grant_nxt;
   logic       r_m0_grant;
   logic       r_m1_grant;
   logic       w_hold_lim;

   assign w_hold_lim = LP_PREEMPT_EN && (r_hold_cnt >= LP_MAX_HOLD);

   // Next-state decode: arbitration, release and hold-limit preemption
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (M0_req && M1_req) begin
               w_state_nxt = r_last_grant ? ST_GNT0 : ST_GNT1;
            end else if (M0_req) begin
               w_state_nxt = ST_GNT0;
            end else if (M1_req) begin
               w_state_nxt = ST_GNT1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GNT0: begin
            if (!M0_req) begin
               w_state_nxt = M1_req ? ST_GNT1 : ST_IDLE;
            end else if (M1_req && w_hold_lim) begin
               w_state_nxt = ST_GNT1;
            end else begin
               w_state_nxt = ST_GNT0;
            end
         end
         ST_GNT1: begin
            if (!M1_req) begin
               w_state_nxt = M0_req ? ST_GNT0 : ST_IDLE;
            end else if (M0_req && w_hold_lim) begin
               w_state_nxt = ST_GNT0;
            end else begin
               w_state_nxt = ST_GNT1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Hold counter and round-robin pointer; a fresh grant restarts the count at 1
   always_comb begin
      w_hold_cnt_nxt   = r_hold_cnt;
      w_last_grant_nxt = r_last_grant;
      if (w_state_nxt == ST_IDLE) begin
         w_hold_cnt_nxt = 8'd0;
      end else if (w_state_nxt != r_state) begin
         w_hold_cnt_nxt   = 8'd1;
         w_last_grant_nxt = (w_state_nxt == ST_GNT1);
      end else if (r_hold_cnt == 8'd255) begin
         w_hold_cnt_nxt = 8'd255;
      end else begin
         w_hold_cnt_nxt = r_hold_cnt + 8'd1;
      end
   end

   // State, counter and grant registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_hold_cnt   <= 8'd0;
         r_last_grant <= 1'b1;
         r_m0_grant   <= 1'b0;
         r_m1_grant   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_hold_cnt   <= w_hold_cnt_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_m0_grant   <= (w_state_nxt == ST_GNT0);
         r_m1_grant   <= (w_state_nxt == ST_GNT1);
      end
   end

   assign M0_grant = r_m0_grant;
   assign M1_grant = r_m1_grant;
   assign M_din    = bus_din;

   // Bus mux: only the granted master reaches the slave; idle drives zeros
   always_comb begin
      bus_sel     = 1'b0;
      bus_wr      = 1'b0;
      bus_address = {ADDR_W{1'b0}};
      bus_dout    = {DATA_W{1'b0}};
      case (r_state)
         ST_GNT0: begin
            bus_sel     = 1'b1;
            bus_wr      = M0_wr;
            bus_address = M0_address;
            bus_dout    = M0_dout;
         end
         ST_GNT1: begin
            bus_sel     = 1'b1;
            bus_wr      = M1_wr;
            bus_address = M1_address;
            bus_dout    = M1_dout;
         end
         default: begin
            bus_sel     = 1'b0;
            bus_wr      = 1'b0;
            bus_address = {ADDR_W{1'b0}};
            bus_dout    = {DATA_W{1'b0}};
         end
      endcase
   end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed scoreboard bench for dma_bus_arbiter: one instance with MAX_HOLD=4
// and one with preemption disabled, both fed the same stimulus.
module tb_dma_bus_arbiter;

   logic        Clk;
   logic        reset_n;
   logic        M0_req, M0_wr, M1_req, M1_wr;
   logic [7:0]  M0_address, M1_address;
   logic [31:0] M0_dout, M1_dout, bus_din;

   logic        a_m0_grant, a_m1_grant, a_sel, a_wr;
   logic [7:0]  a_addr;
   logic [31:0] a_dout, a_mdin;
   logic        b_m0_grant, b_m1_grant, b_sel, b_wr;
   logic [7:0]  b_addr;
   logic [31:0] b_dout, b_mdin;

   logic [43:0] obs_a, obs_b;
   assign obs_a = {a_m0_grant, a_m1_grant, a_sel, a_wr, a_addr, a_dout};
   assign obs_b = {b_m0_grant, b_m1_grant, b_sel, b_wr, b_addr, b_dout};

   typedef struct {
      string       tag;
      int          dut;
      logic [43:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  check_cnt = 0;
   int  err_cnt   = 0;

   dma_bus_arbiter #(.MAX_HOLD(4), .ADDR_W(8), .DATA_W(32)) u_dut_a (
      .Clk(Clk), .reset_n(reset_n),
      .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
      .M0_grant(a_m0_grant),
      .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout),
      .M1_grant(a_m1_grant),
      .bus_sel(a_sel), .bus_wr(a_wr), .bus_address(a_addr), .bus_dout(a_dout),
      .bus_din(bus_din), .M_din(a_mdin)
   );

   dma_bus_arbiter #(.MAX_HOLD(0), .ADDR_W(8), .DATA_W(32)) u_dut_b (
      .Clk(Clk), .reset_n(reset_n),
      .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
      .M0_grant(b_m0_grant),
      .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout),
      .M1_grant(b_m1_grant),
      .bus_sel(b_sel), .bus_wr(b_wr), .bus_address(b_addr), .bus_dout(b_dout),
      .bus_din(bus_din), .M_din(b_mdin)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // g: 0 = idle, 1 = M0 granted, 2 = M1 granted after the coming edge
   task automatic cyc(input string tag, input int dut, input logic [1:0] g);
      sb_t         e;
      logic [43:0] obs;
      e.tag = tag;
      e.dut = dut;
      case (g)
         2'd1:    e.exp = {1'b1, 1'b0, 1'b1, M0_wr, M0_address, M0_dout};
         2'd2:    e.exp = {1'b0, 1'b1, 1'b1, M1_wr, M1_address, M1_dout};
         default: e.exp = 44'd0;
      endcase
      sb_q.push_back(e);
      @(posedge Clk);
      #1;
      e   = sb_q.pop_front();
      obs = (e.dut == 0) ? obs_a : obs_b;
      check_cnt++;
      assert (obs === e.exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc("reset", 0, 2'd0);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n    = 1'b0;
      M0_req     = 1'b0;
      M0_wr      = 1'b0;
      M0_address = 8'h00;
      M0_dout    = 32'h0;
      M1_req     = 1'b0;
      M1_wr      = 1'b0;
      M1_address = 8'h00;
      M1_dout    = 32'h0;
      bus_din    = 32'h0;

      // Reset state on both instances
      cyc("reset_a", 0, 2'd0);
      cyc("reset_b", 1, 2'd0);
      reset_n = 1'b1;

      // M1 alone: one-cycle latency, bus carries M1 address, read data broadcast
      M1_req     = 1'b1;
      M1_address = 8'h0a;
      M1_wr      = 1'b0;
      M1_dout    = 32'h0000_0055;
      bus_din    = 32'h0000_1234;
      cyc("m1_only_grant", 0, 2'd2);
      check_cnt++;
      assert (a_mdin === 32'h0000_1234) else begin
         err_cnt++;
         $error("FAIL m_din observed=%h expected=%h", a_mdin, 32'h0000_1234);
      end
      M1_req = 1'b0;
      cyc("m1_release_idle", 0, 2'd0);

      // Simultaneous request: M0 first, back-to-back handover, M0 waits
      do_reset();
      M0_req     = 1'b1;
      M0_wr      = 1'b1;
      M0_address = 8'h20;
      M0_dout    = 32'hcafe_0001;
      M1_req     = 1'b1;
      M1_address = 8'h30;
      M1_dout    = 32'h0000_0030;
      cyc("rr_m0_first_1", 0, 2'd1);
      cyc("rr_m0_first_2", 0, 2'd1);
      cyc("rr_m0_first_3", 0, 2'd1);
      M0_req = 1'b0;
      cyc("rr_handover", 0, 2'd2);
      M0_req = 1'b1;
      cyc("rr_m0_waits_1", 0, 2'd2);
      cyc("rr_m0_waits_2", 0, 2'd2);
      M1_req = 1'b0;
      cyc("rr_m0_after_m1", 0, 2'd1);
      M0_req = 1'b0;
      cyc("rr_idle", 0, 2'd0);

      // MAX_HOLD=4 preemption of M1 by M0
      do_reset();
      M1_req = 1'b1;
      cyc("hold_m1_c1", 0, 2'd2);
      cyc("hold_m1_c2", 0, 2'd2);
      M0_req = 1'b1;
      cyc("hold_m1_c3", 0, 2'd2);
      cyc("hold_m1_c4", 0, 2'd2);
      cyc("hold_preempt", 0, 2'd1);
      cyc("hold_m0_c2", 0, 2'd1);
      M0_req = 1'b0;
      cyc("hold_m1_regrant", 0, 2'd2);

      // MAX_HOLD=0: no preemption during a long M1 burst
      M1_req = 1'b0;
      do_reset();
      M1_req = 1'b1;
      cyc("nohold_m1_grant", 1, 2'd2);
      M0_req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cyc("nohold_m0_waits", 1, 2'd2);
      end
      M1_req = 1'b0;
      cyc("nohold_m0_grant", 1, 2'd1);
      M0_req = 1'b0;

      // Ungranted M0 write strobe must not reach the bus
      do_reset();
      M0_wr      = 1'b1;
      M0_address = 8'hee;
      M0_dout    = 32'hdead_beef;
      M1_req     = 1'b1;
      M1_wr      = 1'b1;
      M1_address = 8'h14;
      M1_dout    = 32'h0000_0014;
      cyc("wr_m1_bus", 0, 2'd2);
      check_cnt++;
      assert ({a_wr, a_addr, a_dout} === {1'b1, 8'h14, 32'h0000_0014}) else begin
         err_cnt++;
         $error("FAIL wr_bus_fields observed=%h expected=%h",
                {a_wr, a_addr, a_dout}, {1'b1, 8'h14, 32'h0000_0014});
      end
      M1_wr = 1'b0;
      cyc("wr_m1_read", 0, 2'd2);

      // Reset during GNT1 with both requests held
      M0_req  = 1'b1;
      reset_n = 1'b0;
      cyc("midgrant_reset", 0, 2'd0);
      reset_n = 1'b1;
      cyc("post_reset_m0_first", 0, 2'd1);
      M0_req = 1'b0;
      M1_req = 1'b0;
      cyc("final_idle", 0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule
